// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream receive skid slice.
//
// Contents:
//   AXIS_DEPTH  number of beats the slice can hold
//   AXIS_CNT_W  width of the occupancy counter
//   ST_*        occupancy-based state encoding (EMPTY / ONE / FULL)
//   next_count  occupancy update for one clock of push/pop activity
package axis_pkg;

    localparam int unsigned AXIS_DEPTH = 2;
    localparam int unsigned AXIS_CNT_W = 2;

    typedef logic [AXIS_CNT_W-1:0] axis_cnt_t;

    // The state of the slice is exactly its occupancy.
    localparam axis_cnt_t ST_EMPTY = 2'd0;
    localparam axis_cnt_t ST_ONE   = 2'd1;
    localparam axis_cnt_t ST_FULL  = 2'd2;

    // Push together with pop leaves the occupancy unchanged.
    function automatic axis_cnt_t next_count(input axis_cnt_t cnt,
                                             input logic      push,
                                             input logic      pop);
        axis_cnt_t res;
        res = cnt;
        unique case ({push, pop})
            2'b10:   res = axis_cnt_t'(cnt + 2'd1);
            2'b01:   res = axis_cnt_t'(cnt - 2'd1);
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/axis_skid_rx.sv
// AXI-Stream receive slice with a registered s_axis_tready.
//
// Two-entry circular store: the upstream ready is computed from the
// next-state occupancy and registered, so the one beat that can still arrive
// after downstream back-pressure appears always has a free slot.
// Latency is one cycle; throughput is one beat per cycle while m_axis_tready=1.
//
// Ports:
//   clk            clock, rising edge
//   rstn           synchronous active-low reset
//   s_axis_t*      upstream slave stream (tvalid/tdata/tlast in, tready out)
//   m_axis_t*      downstream master stream (tvalid/tdata/tlast out, tready in)
//   occupancy      number of beats currently held (0..2)
module axis_skid_rx
    import axis_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          s_axis_tvalid,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [1:0]                    occupancy
);

    axis_cnt_t count_q, count_d;
    logic      wp_q, wp_d;
    logic      rp_q, rp_d;
    logic      tready_q, tready_d;

    logic [C_AXIS_TDATA_WIDTH-1:0] mem_data_q [AXIS_DEPTH];
    logic                          mem_last_q [AXIS_DEPTH];

    logic push;
    logic pop;

    // The FULL guard only matters if an upstream ignores tready; such a beat
    // is dropped instead of overwriting the oldest entry.
    assign push = s_axis_tvalid & tready_q & (count_q != ST_FULL);
    assign pop  = (count_q != ST_EMPTY) & m_axis_tready;

    always_comb begin
        count_d  = next_count(count_q, push, pop);
        wp_d     = wp_q ^ push;
        rp_d     = rp_q ^ pop;
        // Registered ready looks one cycle ahead so a push accepted while the
        // consumer stalls still lands in the spare entry.
        tready_d = (count_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q  <= ST_EMPTY;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            tready_q <= tready_d;
        end
    end

    // Payload storage needs no reset; validity is carried by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wp_q] <= s_axis_tdata;
            mem_last_q[wp_q] <= s_axis_tlast;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = (count_q != ST_EMPTY);
    assign m_axis_tdata  = mem_data_q[rp_q];
    assign m_axis_tlast  = mem_last_q[rp_q];
    assign occupancy     = count_q;

endmodule

// File: tb/tb_axis_skid_rx.sv
// Directed and randomised bench for axis_skid_rx.
module tb_axis_skid_rx;
    import axis_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rstn;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_last;
    logic         s_ready;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         m_ready;
    logic [1:0]   occ;

    int n_pass  = 0;
    int n_total = 0;

    axis_skid_rx #(.C_AXIS_TDATA_WIDTH(W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tdata  (m_data),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .occupancy     (occ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Checks the full visible state in one call.
    task automatic chk_state(input string tag, input logic exp_ready, input logic [1:0] exp_occ);
        chk({tag, ".s_ready"}, 64'(s_ready), 64'(exp_ready));
        chk({tag, ".m_valid"}, 64'(m_valid), 64'(exp_occ != 2'd0));
        chk({tag, ".occ"},     64'(occ),     64'(exp_occ));
    endtask

    task automatic chk_head(input string tag, input logic [W-1:0] exp_data, input logic exp_last);
        chk({tag, ".data"}, 64'(m_data), 64'(exp_data));
        chk({tag, ".last"}, 64'(m_last), 64'(exp_last));
    endtask

    logic [W:0]   sb_q [$];
    logic [W:0]   exp_beat;
    logic [W-1:0] prev_data;
    logic         prev_stall;
    logic         do_push;
    logic         do_pop;
    logic         seen_full;
    int           sent;
    int           rcvd;
    int           cyc;

    initial begin
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        // Reset and release
        repeat (3) tick();
        chk_state("rst", 1'b0, 2'd0);
        rstn = 1'b1;
        #1;
        chk_state("rel0", 1'b0, 2'd0);
        tick();
        chk_state("rel1", 1'b1, 2'd0);

        // Streaming 16 beats with downstream always ready
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = W'(i + 1);
            s_last  = (i == 15);
            tick();
            chk_state($sformatf("str%0d", i), 1'b1, 2'd1);
            chk_head($sformatf("str%0d", i), W'(i + 1), (i == 15));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        chk_state("str_end", 1'b1, 2'd0);

        // Stall with continuous input
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hA0;
        tick();
        chk_state("stl0", 1'b1, 2'd1);
        chk_head("stl0", 32'hA0, 1'b0);
        s_data = 32'hA1;
        tick();
        chk_state("stl1", 1'b0, 2'd2);
        chk_head("stl1", 32'hA0, 1'b0);
        s_data = 32'hA2;
        tick();
        chk_state("stl2", 1'b0, 2'd2);
        chk_head("stl2", 32'hA0, 1'b0);
        m_ready = 1'b1;
        tick();
        chk_state("drn0", 1'b1, 2'd1);
        chk_head("drn0", 32'hA1, 1'b0);
        tick();
        chk_state("drn1", 1'b1, 2'd1);
        chk_head("drn1", 32'hA2, 1'b0);
        s_valid = 1'b0;
        tick();
        chk_state("drn2", 1'b1, 2'd0);

        // One-cycle release from FULL while upstream keeps offering
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hC0;
        tick();
        s_data = 32'hC1;
        tick();
        chk_state("full", 1'b0, 2'd2);
        m_ready = 1'b1;
        s_data  = 32'hC2;
        tick();
        chk_state("rls0", 1'b1, 2'd1);
        chk_head("rls0", 32'hC1, 1'b0);
        m_ready = 1'b0;
        tick();
        chk_state("rls1", 1'b0, 2'd2);
        chk_head("rls1", 32'hC1, 1'b0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        chk_state("rls2", 1'b1, 2'd1);
        chk_head("rls2", 32'hC2, 1'b0);
        tick();
        chk_state("rls3", 1'b1, 2'd0);

        // Random valid/ready against a scoreboard
        sent       = 0;
        rcvd       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        seen_full  = 1'b0;
        while (rcvd < 1000 && cyc < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (!s_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
                s_valid = 1'b1;
                s_data  = $urandom;
                s_last  = 1'($urandom_range(0, 1));
            end
            if (prev_stall) chk("rnd.stable", 64'(m_data), 64'(prev_data));
            if (occ == ST_FULL) seen_full = 1'b1;
            do_push = s_valid & s_ready;
            do_pop  = m_valid & m_ready;
            if (do_pop) begin
                if (sb_q.size() == 0) begin
                    chk("rnd.spurious", 64'(m_data), 64'hDEAD);
                end else begin
                    exp_beat = sb_q.pop_front();
                    chk("rnd.beat", 64'({m_last, m_data}), 64'(exp_beat));
                end
                rcvd++;
            end
            if (do_push) begin
                sb_q.push_back({s_last, s_data});
                sent++;
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
            tick();
            cyc++;
            if (do_push) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("rnd.count", 64'(rcvd), 64'd1000);
        chk("rnd.full_seen", 64'(seen_full), 64'd1);

        // Reset with two beats held
        m_ready = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hD0;
        tick();
        s_data = 32'hD1;
        tick();
        chk_state("mrst_pre", 1'b0, 2'd2);
        s_valid = 1'b0;
        rstn    = 1'b0;
        tick();
        chk_state("mrst", 1'b0, 2'd0);
        rstn = 1'b1;
        tick();
        chk_state("mrst_rel", 1'b1, 2'd0);
        s_valid = 1'b1;
        s_data  = 32'hB0;
        tick();
        chk_state("b0", 1'b1, 2'd1);
        chk_head("b0", 32'hB0, 1'b0);
        s_data = 32'hB1;
        tick();
        chk_state("b1", 1'b0, 2'd2);
        chk_head("b1", 32'hB0, 1'b0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        chk_state("b2", 1'b1, 2'd1);
        chk_head("b2", 32'hB1, 1'b0);
        tick();
        chk_state("b3", 1'b1, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
